// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// One bit lasts eff_ps CLK cycles, where eff_ps is Prescale (0 treated as 1) latched at acceptance.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned BitW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] ps_q, ps_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic                  wrap;
  logic [BitW-1:0]       bit_nxt;

  assign wrap    = (cnt_q == ps_q - 1'b1);
  assign bit_nxt = bit_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    ps_d      = ps_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    busy_d    = busy_q;

    if (state_q != StIdle) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        cnt_d  = '0;
        bit_d  = '0;
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          ps_d      = (Prescale == '0) ? PRESCALE_W'(1) : Prescale;
          state_d   = StStart;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
        end
      end
      StStart: begin
        if (wrap) begin
          state_d = StData;
          bit_d   = '0;
          tx_d    = data_q[0];
        end
      end
      StData: begin
        if (wrap) begin
          if (bit_q == BitW'(DATA_WIDTH - 1)) begin
            if (par_en_q) begin
              state_d = StParity;
              tx_d    = (^data_q) ^ par_typ_q;
            end else begin
              state_d = StStop;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_nxt;
            tx_d  = data_q[bit_nxt];
          end
        end
      end
      StParity: begin
        if (wrap) begin
          state_d = StStop;
          tx_d    = 1'b1;
        end
      end
      StStop: begin
        // Busy drops on the same edge the state returns to idle.
        if (wrap) begin
          state_d = StIdle;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      ps_q      <= '0;
      cnt_q     <= '0;
      bit_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      ps_q      <= ps_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame: every cycle of each frame is compared
// against a bit sequence built from the byte, parity settings and effective prescale.
module tb_uart_tx_frame;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       Busy;

  int tests  = 0;
  int failed = 0;

  uart_tx_frame #(
    .DATA_WIDTH(8),
    .PRESCALE_W(6)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .Data_Valid(Data_Valid),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .Prescale  (Prescale),
    .TX_OUT    (TX_OUT),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " tx"}, {31'd0, TX_OUT}, 32'd1);
    check({tag, " busy"}, {31'd0, Busy}, 32'd0);
  endtask

  // Present a request for one cycle; returns just after the acceptance edge.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [5:0] ps);
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    Prescale   = ps;
    Data_Valid = 1'b1;
    tick();
    Data_Valid = 1'b0;
  endtask

  // Called just after the acceptance edge. mode: 0 none, 1 disturb inputs while busy,
  // 2 switch P_DATA to 0xAA keeping Data_Valid high, 3 drop Data_Valid.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic pt, input int eff, input int mode);
    logic bits[11];
    int   nbits;
    int   cyc;
    nbits   = pe ? 11 : 10;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    if (pe) bits[9] = (^d) ^ pt;
    bits[nbits-1] = 1'b1;
    cyc = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < eff; c++) begin
        check($sformatf("%s bit%0d cyc%0d tx", tag, b, c), {31'd0, TX_OUT}, {31'd0, bits[b]});
        check($sformatf("%s bit%0d cyc%0d busy", tag, b, c), {31'd0, Busy}, 32'd1);
        if (cyc == 5) begin
          case (mode)
            1: begin
              P_DATA     = 8'hFF;
              PAR_EN     = 1'b1;
              PAR_TYP    = 1'b1;
              Prescale   = 6'd3;
              Data_Valid = 1'b1;
            end
            2: P_DATA = 8'hAA;
            3: Data_Valid = 1'b0;
            default: ;
          endcase
        end
        if (cyc == 6 && mode == 1) Data_Valid = 1'b0;
        cyc++;
        tick();
      end
    end
    check_idle({tag, " end"});
  endtask

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    Prescale   = 6'd8;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("reset cyc%0d", i));
    end
    RST = 1'b1;
    tick();
    check_idle("post reset");

    // Reset during data bit 3 of 0xFF (frame bit 4 covers cycles 32..39)
    start_frame(8'hFF, 1'b0, 1'b0, 6'd8);
    repeat (34) tick();
    check("pre abort busy", {31'd0, Busy}, 32'd1);
    RST = 1'b0;
    #1;
    check_idle("abort async");
    tick();
    check_idle("abort held");
    RST = 1'b1;
    tick();
    check_idle("abort released");

    // Basic frame 0xA5, no parity
    start_frame(8'hA5, 1'b0, 1'b0, 6'd8);
    expect_frame("a5", 8'hA5, 1'b0, 1'b0, 8, 0);

    // Parity, both polarities
    start_frame(8'h03, 1'b1, 1'b0, 6'd16);
    expect_frame("p03e", 8'h03, 1'b1, 1'b0, 16, 0);
    tick();
    start_frame(8'h03, 1'b1, 1'b1, 6'd16);
    expect_frame("p03o", 8'h03, 1'b1, 1'b1, 16, 0);
    tick();
    start_frame(8'h07, 1'b1, 1'b0, 6'd16);
    expect_frame("p07e", 8'h07, 1'b1, 1'b0, 16, 0);

    // Busy protection: requests and input changes mid-frame are ignored
    tick();
    start_frame(8'h3C, 1'b0, 1'b0, 6'd8);
    expect_frame("busy3c", 8'h3C, 1'b0, 1'b0, 8, 1);
    P_DATA   = 8'h00;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = 6'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("no second frame %0d", i));
    end

    // Back-to-back with Data_Valid held high
    P_DATA     = 8'h55;
    Prescale   = 6'd4;
    Data_Valid = 1'b1;
    tick();
    expect_frame("b2b55", 8'h55, 1'b0, 1'b0, 4, 2);
    tick();
    expect_frame("b2baa", 8'hAA, 1'b0, 1'b0, 4, 3);
    tick();
    check_idle("b2b after");

    // Prescale corners
    start_frame(8'h81, 1'b0, 1'b0, 6'd0);
    expect_frame("ps0", 8'h81, 1'b0, 1'b0, 1, 0);
    tick();
    start_frame(8'h81, 1'b0, 1'b0, 6'd63);
    expect_frame("ps63", 8'h81, 1'b0, 1'b0, 63, 0);
    tick();
    check_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
